nibble_serial_adder_ctrl: RTL and testbench

Sequencer that performs wide add/subtract by time-multiplexing one four_bit_adder instance over NIBBLES nibble slices, least-significant first, with a registered carry between slices. It accepts operands over a valid/ready input handshake and returns the result over a valid/ready output handshake. It sits between a requester, such as a small ALU or accumulator, and the shared 4-bit adder datapath, trading latency for area.

---
 rtl/nibble_serial_adder_ctrl.sv | 128 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequencer: one 4-bit adder slice is reused over NIBBLES cycles,
// least-significant nibble first, with the carry held in a register between slices.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   Sub,
  input  logic                   Cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   Sum,
  output logic                   Cout,
  output logic                   Ovf,
  output logic                   busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = $clog2(NIBBLES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, a_sign_q, a_sign_d, b_sign_q, b_sign_d;
  logic            cout_q, cout_d, ovf_q, ovf_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    beff;
  logic [4:0]      nib_add;
  logic            accept, last_slice;

  assign beff       = Sub ? ~B : B;
  assign accept     = (state_q == StIdle) && in_valid;
  assign last_slice = (k_q == KW'(NIBBLES - 1));

  // The shared 4-bit adder slice; operands always come from the low nibble of the shift regs.
  assign nib_add = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    k_d      = k_q;
    if (accept) begin
      a_d      = A;
      b_d      = beff;
      carry_d  = Sub ? 1'b1 : Cin;
      a_sign_d = A[W-1];
      b_sign_d = beff[W-1];
      k_d      = '0;
    end else if (state_q == StRun) begin
      // Only the active slice's bits of Sum change; upper bits keep the stale result.
      for (int i = 0; i < int'(NIBBLES); i++) begin
        if (k_q == KW'(i)) sum_d[4*i +: 4] = nib_add[3:0];
      end
      carry_d = nib_add[4];
      a_d     = a_q >> 4;
      b_d     = b_q >> 4;
      k_d     = k_q + 1'b1;
      if (last_slice) begin
        cout_d = nib_add[4];
        ovf_d  = (a_sign_q == b_sign_q) && (nib_add[3] != a_sign_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      k_q      <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      k_q      <= k_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: a 4-nibble and a 2-nibble instance
// driven with hand-computed vectors.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-nibble instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        sub = 1'b0, cin = 1'b0, cout, ovf, busy;

  // 2-nibble instance
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0, sum2;
  logic        cout2, ovf2, busy2;

  int total = 0;
  int bad = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Sub(sub), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(sum), .Cout(cout), .Ovf(ovf), .busy(busy)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(a2), .B(b2), .Sub(1'b0), .Cin(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
    .Sum(sum2), .Cout(cout2), .Ovf(ovf2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands until accepted; returns at 1 time unit after the accept edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input logic tc);
    logic acc;
    int   tries;
    a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
    tries = 0;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end while (!acc && tries < 20);
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'(tries), 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic tc, input logic [15:0] es,
                        input logic ec, input logic eo);
    int lat;
    start_op(ta, tb_v, ts, tc);
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int acc_edges[$];
    #12;
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_cin1",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_zero",  16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);

    // Operands offered while busy must be ignored, and DONE must hold under backpressure.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1; in_valid = 1'b1;
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h3333);
      check("bp_flags", {30'd0, cout, ovf}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", 32'(out_valid), 32'd0);

    // Asynchronous abort after the second RUN edge.
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // 2-nibble instance: single op latency and result.
    a2 = 8'hFF; b2 = 8'h01; in_valid2 = 1'b1;
    check("n2_ready", 32'(in_ready2), 32'd1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid2 && lat < 20);
    check("n2_latency", 32'(lat), 32'd2);
    check("n2_sum", 32'(sum2), 32'h00);
    check("n2_cout", 32'(cout2), 32'd1);
    check("n2_ovf", 32'(ovf2), 32'd0);
    out_ready2 = 1'b1;
    @(posedge clk); #1;

    // Back-to-back with constant handshakes: accepts every NIBBLES+2 edges.
    a2 = 8'h12; b2 = 8'h34; in_valid2 = 1'b1;
    for (int e = 0; e < 14; e++) begin
      if (in_ready2) acc_edges.push_back(e);
      @(posedge clk); #1;
      if (out_valid2) check("n2_b2b_sum", 32'(sum2), 32'h46);
    end
    in_valid2 = 1'b0;
    check("n2_b2b_count", 32'(acc_edges.size()), 32'd4);
    for (int i = 1; i < acc_edges.size(); i++)
      check("n2_b2b_spacing", 32'(acc_edges[i] - acc_edges[i-1]), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
